imsic_intp_file: RTL and testbench

- One IMSIC interrupt file: consumes the setipnum write strobe produced by the IMSIC register map for one privilege level / guest.
- Holds the pending (eip) and enable (eie) bit arrays, plus eidelivery and eithreshold.
- Computes the registered top external interrupt (topei) and the interrupt line to the hart.
- Exposes a CSR-side indirect access port (iselect-style addresses) and a claim strobe.

---
 rtl/imsic_intp_file.sv | 130 +++++++++++++
 tb/tb_imsic_intp_file.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_intp_file.sv
`default_nettype none
// ============================================================================
// Module   : imsic_intp_file
// Purpose  : One IMSIC interrupt file: pending/enable arrays, eidelivery,
//            eithreshold, registered topei and hart interrupt line.
// Revision : 1.0 - initial release
// ============================================================================
module imsic_intp_file #(
    parameter int NR_SRC     = 64,
    parameter int NR_SRC_LEN = 32,
    parameter int ID_W       = $clog2(NR_SRC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NR_SRC_LEN-1:0] i_setipnum,
    input  logic                  i_setipnum_we,
    input  logic [7:0]            i_csr_addr,
    input  logic [31:0]           i_csr_wdata,
    input  logic                  i_csr_we,
    input  logic                  i_csr_re,
    output logic [31:0]           o_csr_rdata,
    output logic                  o_csr_rvalid,
    input  logic                  i_claim,
    output logic [ID_W-1:0]       o_topei,
    output logic                  o_irq
);

    localparam int c_nr_reg = NR_SRC / 32;

    logic [NR_SRC-1:0] r_eip;
    logic [NR_SRC-1:0] r_eie;
    logic              r_eidelivery;
    logic [ID_W-1:0]   r_eithreshold;
    logic [31:0]       r_csr_rdata;
    logic              r_csr_rvalid;
    logic [ID_W-1:0]   r_topei;
    logic              r_irq;

    logic [NR_SRC-1:0] w_eip_next;
    logic [NR_SRC-1:0] w_eie_next;
    logic [ID_W-1:0]   w_topei;
    logic [31:0]       w_rdata;
    logic              w_set_ok;
    logic              w_eip_sel;
    logic              w_eie_sel;
    logic [5:0]        w_idx;

    assign w_eip_sel = (i_csr_addr[7:6] == 2'b10);
    assign w_eie_sel = (i_csr_addr[7:6] == 2'b11);
    assign w_idx     = i_csr_addr[5:0];
    // Full-width compare also rejects any stray bits above ID_W.
    assign w_set_ok  = i_setipnum_we && (i_setipnum != '0) &&
                       (i_setipnum < NR_SRC_LEN'(NR_SRC));

    // Update order gives CSR write < claim clear < setipnum set.
    always_comb begin
        w_eip_next = r_eip;
        w_eie_next = r_eie;
        if (i_csr_we) begin
            for (int k = 0; k < c_nr_reg; k++) begin
                if (w_eip_sel && (w_idx == 6'(k)))
                    w_eip_next[32*k +: 32] = i_csr_wdata;
                if (w_eie_sel && (w_idx == 6'(k)))
                    w_eie_next[32*k +: 32] = i_csr_wdata;
            end
        end
        if (i_claim && (r_topei != '0))
            w_eip_next[r_topei] = 1'b0;
        if (w_set_ok)
            w_eip_next[i_setipnum[ID_W-1:0]] = 1'b1;
        w_eip_next[0] = 1'b0;
        w_eie_next[0] = 1'b0;
    end

    // Descending scan so the lowest-numbered candidate is the last to assign.
    always_comb begin
        w_topei = '0;
        for (int i = NR_SRC - 1; i > 0; i--) begin
            if (r_eip[i] && r_eie[i] &&
                ((r_eithreshold == '0) || (ID_W'(i) < r_eithreshold)))
                w_topei = ID_W'(i);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (i_csr_addr == 8'h70)
            w_rdata[0] = r_eidelivery;
        if (i_csr_addr == 8'h72)
            w_rdata[ID_W-1:0] = r_eithreshold;
        for (int k = 0; k < c_nr_reg; k++) begin
            if (w_eip_sel && (w_idx == 6'(k)))
                w_rdata = r_eip[32*k +: 32];
            if (w_eie_sel && (w_idx == 6'(k)))
                w_rdata = r_eie[32*k +: 32];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_eip         <= '0;
            r_eie         <= '0;
            r_eidelivery  <= 1'b0;
            r_eithreshold <= '0;
            r_csr_rdata   <= '0;
            r_csr_rvalid  <= 1'b0;
            r_topei       <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_eip <= w_eip_next;
            r_eie <= w_eie_next;
            if (i_csr_we && (i_csr_addr == 8'h70))
                r_eidelivery <= i_csr_wdata[0];
            if (i_csr_we && (i_csr_addr == 8'h72))
                r_eithreshold <= i_csr_wdata[ID_W-1:0];
            if (i_csr_re)
                r_csr_rdata <= w_rdata;
            r_csr_rvalid <= i_csr_re;
            r_topei      <= w_topei;
            r_irq        <= r_eidelivery && (w_topei != '0);
        end
    end

    assign o_csr_rdata  = r_csr_rdata;
    assign o_csr_rvalid = r_csr_rvalid;
    assign o_topei      = r_topei;
    assign o_irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_imsic_intp_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_imsic_intp_file
// Purpose  : Directed self-checking bench for imsic_intp_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imsic_intp_file;

    localparam int NR_SRC = 64;
    localparam int ID_W   = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] setipnum = '0;
    logic        setipnum_we = 1'b0;
    logic [7:0]  csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_we = 1'b0;
    logic        csr_re = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        claim = 1'b0;
    logic [ID_W-1:0] topei;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imsic_intp_file #(.NR_SRC(NR_SRC), .NR_SRC_LEN(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_setipnum(setipnum), .i_setipnum_we(setipnum_we),
        .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
        .i_csr_we(csr_we), .i_csr_re(csr_re),
        .o_csr_rdata(csr_rdata), .o_csr_rvalid(csr_rvalid),
        .i_claim(claim), .o_topei(topei), .o_irq(irq)
    );

    // ---------------- behavioural model ----------------
    bit m_eip [NR_SRC];
    bit m_eie [NR_SRC];
    bit m_deliv;
    int m_thr;
    int m_topei;
    bit m_irq;
    bit m_rvalid;
    int unsigned m_rdata;

    function automatic int best_id();
        for (int id = 1; id < NR_SRC; id++)
            if (m_eip[id] && m_eie[id] && (m_thr == 0 || id < m_thr))
                return id;
        return 0;
    endfunction

    function automatic int unsigned reg_val(input logic [7:0] a);
        int unsigned v = 0;
        if (a == 8'h70) return {31'd0, m_deliv};
        if (a == 8'h72) return m_thr;
        if (a >= 8'h80 && a < 8'h80 + NR_SRC/32) begin
            for (int j = 0; j < 32; j++) if (m_eip[32*(a-8'h80)+j]) v |= (1 << j);
            return v;
        end
        if (a >= 8'hC0 && a < 8'hC0 + NR_SRC/32) begin
            for (int j = 0; j < 32; j++) if (m_eie[32*(a-8'hC0)+j]) v |= (1 << j);
            return v;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_SRC; i++) begin m_eip[i] = 0; m_eie[i] = 0; end
            m_deliv = 0; m_thr = 0; m_topei = 0; m_irq = 0;
            m_rvalid = 0; m_rdata = 0;
        end else begin
            int prev_top;
            int nt;
            prev_top = m_topei;
            nt = best_id();
            if (csr_re) m_rdata = reg_val(csr_addr);
            m_rvalid = csr_re;
            m_irq = m_deliv && (nt != 0);
            m_topei = nt;
            if (csr_we) begin
                if (csr_addr == 8'h70) m_deliv = csr_wdata[0];
                if (csr_addr == 8'h72) m_thr = int'(csr_wdata[ID_W-1:0]);
                if (csr_addr >= 8'h80 && csr_addr < 8'h80 + NR_SRC/32)
                    for (int j = 0; j < 32; j++) m_eip[32*(csr_addr-8'h80)+j] = csr_wdata[j];
                if (csr_addr >= 8'hC0 && csr_addr < 8'hC0 + NR_SRC/32)
                    for (int j = 0; j < 32; j++) m_eie[32*(csr_addr-8'hC0)+j] = csr_wdata[j];
            end
            if (claim && prev_top != 0) m_eip[prev_top] = 0;
            if (setipnum_we && setipnum != 0 && setipnum < NR_SRC) m_eip[setipnum] = 1;
            m_eip[0] = 0;
            m_eie[0] = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (int'(topei) != m_topei) begin
            errors++;
            $display("FAIL model_topei t=%0t actual=%0d required=%0d", $time, topei, m_topei);
        end
        checks++;
        if (irq != m_irq) begin
            errors++;
            $display("FAIL model_irq t=%0t actual=%0b required=%0b", $time, irq, m_irq);
        end
        checks++;
        if (csr_rvalid != m_rvalid) begin
            errors++;
            $display("FAIL model_rvalid t=%0t actual=%0b required=%0b", $time, csr_rvalid, m_rvalid);
        end
        if (m_rvalid) begin
            checks++;
            if (csr_rdata != m_rdata) begin
                errors++;
                $display("FAIL model_rdata t=%0t actual=0x%0h required=0x%0h", $time, csr_rdata, m_rdata);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] a, input int unsigned exp, input string name);
        csr_addr = a; csr_re = 1'b1;
        tick();
        csr_re = 1'b0;
        check({name, "_rvalid"}, csr_rvalid, 1);
        check(name, csr_rdata, exp);
    endtask

    task automatic setip(input logic [31:0] v);
        setipnum = v; setipnum_we = 1'b1;
        tick();
        setipnum_we = 1'b0;
    endtask

    task automatic do_claim();
        claim = 1'b1;
        tick();
        claim = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        check("reset_topei", topei, 0);
        check("reset_irq", irq, 0);
        check("reset_rvalid", csr_rvalid, 0);
        rst = 1'b0;
        tick();

        // First interrupt
        csr_wr(8'h70, 32'h1);
        csr_wr(8'hC0, 32'h20);
        setip(5);
        tick();
        check("first_topei", topei, 5);
        check("first_irq", irq, 1);
        csr_rd(8'h80, 32'h20, "first_eip0");

        // Priority and claim
        csr_wr(8'h80, 32'h0);
        csr_wr(8'hC0, 32'h8);
        csr_wr(8'hC1, 32'h100);
        setip(40);
        setip(3);
        tick();
        check("prio_topei", topei, 3);
        do_claim();
        tick();
        check("claim1_topei", topei, 40);
        do_claim();
        tick();
        check("claim2_topei", topei, 0);
        check("claim2_irq", irq, 0);
        csr_rd(8'h80, 0, "claim_eip0");
        csr_rd(8'h81, 0, "claim_eip1");

        // Threshold
        csr_wr(8'hC0, 32'h1000);
        csr_wr(8'hC1, 32'h0);
        setip(12);
        csr_wr(8'h72, 10);
        tick();
        check("thr10_topei", topei, 0);
        check("thr10_irq", irq, 0);
        csr_wr(8'h72, 13);
        tick();
        check("thr13_topei", topei, 12);
        csr_wr(8'h72, 0);
        tick();
        check("thr0_topei", topei, 12);
        csr_rd(8'h72, 0, "thr_read");
        csr_wr(8'h80, 32'h0);

        // Invalid setipnum, hardwired bit0, unimplemented address
        setip(0);
        setip(64);
        setip(32'h10005);
        tick();
        csr_rd(8'h80, 0, "inv_eip0");
        csr_rd(8'h81, 0, "inv_eip1");
        check("inv_topei", topei, 0);
        csr_wr(8'h80, 32'h1);
        csr_rd(8'h80, 0, "bit0_eip0");
        csr_wr(8'hC0, 32'h1);
        csr_rd(8'hC0, 0, "bit0_eie0");
        csr_wr(8'h82, 32'hFFFF_FFFF);
        csr_rd(8'h82, 0, "unimpl_read");
        csr_wr(8'h70, 32'hFFFF_FFFF);
        csr_rd(8'h70, 1, "deliv_read");

        // Simultaneous claim and set on the same identity
        csr_wr(8'hC0, 32'h80);
        setip(7);
        tick();
        check("simul_pre_topei", topei, 7);
        claim = 1'b1; setipnum = 7; setipnum_we = 1'b1;
        tick();
        claim = 1'b0; setipnum_we = 1'b0;
        tick();
        check("simul_topei", topei, 7);
        csr_rd(8'h80, 32'h80, "simul_eip0");

        // CSR write together with set
        csr_addr = 8'h80; csr_wdata = 0; csr_we = 1'b1;
        setipnum = 9; setipnum_we = 1'b1;
        tick();
        csr_we = 1'b0; setipnum_we = 1'b0;
        csr_rd(8'h80, 32'h200, "wr_set_eip0");

        // Read/write collision
        csr_wr(8'h80, 32'h2);
        csr_addr = 8'h80; csr_wdata = 32'h4; csr_we = 1'b1; csr_re = 1'b1;
        tick();
        csr_we = 1'b0; csr_re = 1'b0;
        check("rw_rvalid", csr_rvalid, 1);
        check("rw_rdata", csr_rdata, 32'h2);
        csr_rd(8'h80, 32'h4, "rw_after");

        // Asynchronous reset mid-operation
        csr_wr(8'hC0, 32'h4);
        tick(2);
        check("prerst_irq", irq, 1);
        check("prerst_topei", topei, 2);
        #2 rst = 1'b1;
        #1;
        check("rst_irq", irq, 0);
        check("rst_topei", topei, 0);
        tick(2);
        rst = 1'b0;
        tick();
        csr_rd(8'h80, 0, "rst_eip0");
        csr_rd(8'hC0, 0, "rst_eie0");
        csr_rd(8'h70, 0, "rst_deliv");
        csr_rd(8'h72, 0, "rst_thr");
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
